// File: rtl/alu_issue_ctrl.sv
// Issue controller for a multi-cycle ALU: registers one request, sequences the
// ALU (single-cycle ops or the long mod engine) and holds the result until taken.
module alu_issue_ctrl #(
  parameter int SIMPLE_WAIT = 1,
  parameter int MOD_WAIT    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [2:0]  req_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_reset,
  input  logic [31:0] alu_result
);

  localparam int MAX_WAIT = (SIMPLE_WAIT > MOD_WAIT) ? SIMPLE_WAIT : MOD_WAIT;
  localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  localparam logic [CNT_W-1:0] SIMPLE_LOAD = CNT_W'(SIMPLE_WAIT - 1);
  localparam logic [CNT_W-1:0] MOD_LOAD    = CNT_W'(MOD_WAIT - 1);
  localparam logic [2:0]       OP_MOD      = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_EXEC,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [31:0]      result_q, result_d;
  logic             err_q, err_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // NOTE: every next-state signal is defaulted to its current value first so
  // no path through the case leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    result_d = result_q;
    err_d    = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          alu_a_d  = req_a;
          alu_b_d  = req_b;
          alu_op_d = req_op;
          if (req_op != OP_MOD) begin
            cnt_d   = SIMPLE_LOAD;
            state_d = S_EXEC;
          end else if (req_b == 32'd0) begin
            // Divide-by-zero never reaches the ALU; dividend is returned as-is.
            result_d = req_a;
            err_d    = 1'b1;
            state_d  = S_RESP;
          end else begin
            state_d = S_START;
          end
        end
      end

      S_START: begin
        cnt_d   = MOD_LOAD;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        if (cnt_q == '0) begin
          result_d = alu_result;
          err_d    = 1'b0;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready  = (state_q == S_IDLE) && !reset;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_result = result_q;
  assign rsp_err    = err_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  // The mod engine runs only while released; every other op ignores alu_reset.
  assign alu_reset  = !((state_q == S_EXEC) && (alu_op_q == OP_MOD));

endmodule
